// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad entry of a new BCD time of day, with digit
// blink feedback, an inactivity timeout and a one-cycle load strobe.
module time_set_ctrl #(
  parameter int TIMEOUT_CYC = 10000,
  parameter int BLINK_HALF  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dip_sw,
  input  logic [9:0]  keypad,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic [2:0]  edit_pos,
  output logic [5:0]  blank_mask,
  output logic        err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    COMMIT,
    WAIT_REL
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;
  logic [23:0]   set_n;
  logic [2:0]    pos_n;
  logic [5:0]    blank_n;
  logic          err_n;
  logic [9:0]    kp_q;
  logic          dip_q;
  logic          key_ev;
  logic [3:0]    key_d;
  logic [3:0]    lim;
  logic          key_ok;

  // Key event: a single key goes down after an all-released sample.
  always_comb begin
    key_ev = 1'b0;
    key_d  = 4'd0;
    if (kp_q == 10'd0 && keypad != 10'd0 &&
        (keypad & (keypad - 10'd1)) == 10'd0) begin
      key_ev = 1'b1;
      for (int k = 0; k < 10; k++)
        if (keypad[k]) key_d = 4'(k);
    end
  end

  // Largest digit allowed at the position under edit.
  always_comb begin
    unique case (edit_pos)
      3'd0:    lim = 4'd2;
      3'd1:    lim = (set_time[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    lim = 4'd5;
      3'd3:    lim = 4'd9;
      3'd4:    lim = 4'd5;
      default: lim = 4'd9;
    endcase
    key_ok = key_ev && (key_d <= lim);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    set_n   = set_time;
    pos_n   = edit_pos;
    timer_n = timer;
    bcnt_n  = bcnt;
    phase_n = phase;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dip_sw && !dip_q) begin
          state_n = ENTRY;
          set_n   = cur_time;
          pos_n   = 3'd0;
          timer_n = '0;
          bcnt_n  = '0;
          phase_n = 1'b0;
        end
      end
      ENTRY: begin
        if (!dip_sw) begin
          state_n = IDLE;
        end else if (key_ok) begin
          for (int p = 0; p < 6; p++)
            if (edit_pos == 3'(p)) set_n[20-4*p +: 4] = key_d;
          if (edit_pos == 3'd0 && key_d == 4'd2 &&
              set_time[19:16] > 4'd3)
            set_n[19:16] = 4'd0;
          timer_n = '0;
          bcnt_n  = '0;
          phase_n = 1'b0;
          if (edit_pos == 3'd5) state_n = COMMIT;
          else pos_n = edit_pos + 3'd1;
        end else begin
          err_n = key_ev;
          if (bcnt == BW'(BLINK_HALF - 1)) begin
            bcnt_n  = '0;
            phase_n = ~phase;
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
          if (timer == TW'(TIMEOUT_CYC - 1)) state_n = IDLE;
          else if (!key_ev) timer_n = timer + TW'(1);
        end
      end
      COMMIT: state_n = WAIT_REL;
      WAIT_REL: begin
        if (!dip_sw) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    blank_n = 6'd0;
    if (state_n == ENTRY && phase_n) blank_n = 6'b1 << pos_n;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      set_time   <= 24'd0;
      load       <= 1'b0;
      edit_pos   <= 3'd0;
      blank_mask <= 6'd0;
      err        <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      kp_q       <= 10'd0;
      dip_q      <= 1'b0;
    end else begin
      state      <= state_n;
      set_time   <= set_n;
      load       <= (state_n == COMMIT);
      edit_pos   <= pos_n;
      blank_mask <= blank_n;
      err        <= err_n;
      busy       <= (state_n == ENTRY);
      timer      <= timer_n;
      bcnt       <= bcnt_n;
      phase      <= phase_n;
      kp_q       <= keypad;
      dip_q      <= dip_sw;
    end
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10000, entry inactivity timeout in clk cycles (10 s at 1 kHz).
REQ-002 Parameter BLINK_HALF, default 250, blink half-period in clk cycles.
REQ-003 clk  in  1  1 kHz system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 dip_sw  in  1  set-mode request (1 = set mode).
REQ-006 keypad  in  10  key levels, bit k = digit k.
REQ-007 cur_time  in  24  running time, packed BCD {h_ten,h_one,m_ten,m_one,s_ten,s_one}, h_ten in [23:20].
REQ-008 set_time  out  24  staged time, same packing as cur_time.
REQ-009 load  out  1  one-cycle pulse; time counter shall capture set_time.
REQ-010 edit_pos  out  3  digit under edit, 0 = h_ten .. 5 = s_one.
REQ-011 blank_mask  out  6  bit i = 1 blanks display digit i (bit i matches edit_pos i).
REQ-012 err  out  1  one-cycle pulse on a rejected key.
REQ-013 busy  out  1  high while state is ENTRY.

Function
REQ-014 States: IDLE, ENTRY, COMMIT, WAIT_REL; all outputs registered.
REQ-015 Key event = keypad one-hot this cycle AND keypad was all-zero last cycle; non-one-hot nonzero patterns produce no event and no err.
REQ-016 IDLE: dip_sw rising edge (1 now, 0 last cycle) -> ENTRY; same edge: set_time <= cur_time, edit_pos <= 0, timer <= 0, blink phase <= 0.
REQ-017 Digit limits: pos0 <= 2; pos1 <= 3 if staged h_ten = 2, else <= 9; pos2 <= 5; pos3 <= 9; pos4 <= 5; pos5 <= 9.
REQ-018 ENTRY valid key: write digit to position edit_pos; edit_pos + 1; timer <= 0; blink phase <= 0.
REQ-019 Writing h_ten = 2 while staged h_one > 3 also forces h_one to 0 in the same cycle.
REQ-020 ENTRY invalid key: err = 1 for exactly one cycle; set_time, edit_pos, timer unchanged.
REQ-021 Valid key at edit_pos 5 -> COMMIT; edit_pos holds at 5 and does not wrap.
REQ-022 COMMIT: load = 1 for exactly one cycle, set_time stable; -> WAIT_REL next cycle.
REQ-023 WAIT_REL: stay until dip_sw = 0, then -> IDLE; keys ignored.
REQ-024 ENTRY with dip_sw = 0: abort -> IDLE, no load; abort takes priority over a simultaneous key.
REQ-025 ENTRY timer increments each cycle without a valid key; at TIMEOUT_CYC-1 with no valid key that cycle -> IDLE, no load; a valid key in that cycle wins.
REQ-026 Blink phase toggles every BLINK_HALF cycles in ENTRY only; blank_mask = one-hot(edit_pos) when phase = 1, else 0; blank_mask = 0 outside ENTRY.
REQ-027 set_time holds its last value in IDLE/WAIT_REL; untouched digits keep the cur_time snapshot.

Reset
REQ-028 rst asserted, at any time including mid-ENTRY or in COMMIT: state IDLE, set_time 0, load 0, err 0, busy 0, edit_pos 0, blank_mask 0, timer and blink phase 0, previous-keypad and previous-dip_sw registers 0.
REQ-029 After rst release with dip_sw already 1 -> ENTRY on the first clock (the prior-sample register resets to 0).

Verification
REQ-030 cur_time 12:34:56, dip_sw 0->1, keys 2,1,0,9,4,5 each pressed and released -> load one cycle, set_time = 0x210945, then WAIT_REL.
REQ-031 Entry at pos0, key 3 -> err one cycle, edit_pos stays 0; keys 2 then 4 -> second err; key 3 accepted.
REQ-032 Staged 19:xx, key 2 at pos0 -> set_time[23:16] = 0x20 (h_one forced 0).
REQ-033 Two valid keys, then dip_sw -> 0 in the same cycle as a key press -> IDLE, load never pulses, set_time[15:0] still equals the cur_time snapshot.
REQ-034 Enter ENTRY, no keys for TIMEOUT_CYC cycles -> IDLE with no load; blank_mask bit 0 toggles every 250 cycles until then.
REQ-035 rst pulsed mid-entry at edit_pos 3 -> all outputs at reset values within the same cycle; a fresh dip_sw edge restarts entry at edit_pos 0.
